// File: rtl/clk_en_ctrl_if.sv
// Configuration handshake bundle for clk_en_ctrl.
// The master presents a new divide-ratio pair with cfg_valid and holds it
// until the controller shows cfg_ready. The slave pulses cfg_done for one
// cycle when the accepted pair becomes the active pair.
//   cfg_valid  master->slave  new ratio pair presented
//   cfg_div0   master->slave  requested en0 ratio
//   cfg_div1   master->slave  requested en1 ratio
//   cfg_ready  slave->master  controller can accept a config
//   cfg_done   slave->master  accepted config is now active (1-cycle pulse)
interface clk_en_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div0;
  logic [CNT_W-1:0] cfg_div1;
  logic             cfg_ready;
  logic             cfg_done;

  modport master (
    output cfg_valid, cfg_div0, cfg_div1,
    input  cfg_ready, cfg_done
  );

  modport slave (
    input  cfg_valid, cfg_div0, cfg_div1,
    output cfg_ready, cfg_done
  );
endinterface

// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl: clock-enable controller. Produces two single-cycle enable
// strobes (en0 pixel-rate, en1 fast-rate) on clk_in instead of derived
// clocks. Ratios are reprogrammed at runtime through the cfg interface and
// only take effect on an en0 boundary, so no runt periods occur.
// A stored ratio of 0 or 1 yields a strobe every cycle.
//
// Ports:
//   clk_in    system clock
//   reset_n   asynchronous active-low reset
//   run       1 = generate strobes, 0 = hold counters cleared
//   cfg       config handshake (clk_en_ctrl_if.slave)
//   en0/en1   registered enable strobes, period div0_cur/div1_cur
//   busy      high while in RUN or PEND
//   div0_cur  active en0 ratio (as written)
//   div1_cur  active en1 ratio (as written)
//   sq0/sq1   debug square waves, period 2*divX (only with SQUARE_OUT_EN)
//
// Build option: define SQUARE_OUT_EN to add the sq0/sq1 debug outputs.
module clk_en_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DIV0_RST = 4,
  parameter int DIV1_RST = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             run,
  clk_en_ctrl_if.slave     cfg,
  output logic             en0,
  output logic             en1,
  output logic             busy,
  output logic [CNT_W-1:0] div0_cur,
  output logic [CNT_W-1:0] div1_cur
`ifdef SQUARE_OUT_EN
  ,
  output logic             sq0,
  output logic             sq1
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] c0_q, c0_d, c1_q, c1_d;
  logic [CNT_W-1:0] div0_cur_q, div0_cur_d, div1_cur_q, div1_cur_d;
  logic [CNT_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic             en0_q, en0_d, en1_q, en1_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             apply;

  logic             accept;
  logic [CNT_W-1:0] eff0, eff1;
  logic             term0, term1;

  assign accept = cfg.cfg_valid & ready_q;

  // Ratios 0 and 1 both count as 1; stored values are left untouched.
  assign eff0  = (div0_cur_q < CNT_W'(2)) ? CNT_W'(1) : div0_cur_q;
  assign eff1  = (div1_cur_q < CNT_W'(2)) ? CNT_W'(1) : div1_cur_q;
  assign term0 = (c0_q == eff0 - CNT_W'(1));
  assign term1 = (c1_q == eff1 - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    div0_cur_d = div0_cur_q;
    div1_cur_d = div1_cur_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    en0_d      = 1'b0;
    en1_d      = 1'b0;
    done_d     = 1'b0;
    apply      = 1'b0;

    case (state_q)
      IDLE: begin
        c0_d = '0;
        c1_d = '0;
        if (accept) begin
          div0_cur_d = cfg.cfg_div0;
          div1_cur_d = cfg.cfg_div1;
          done_d     = 1'b1;
        end
        if (run) state_d = RUN;
      end

      RUN: begin
        if (!run) begin
          state_d = IDLE;
          c0_d    = '0;
          c1_d    = '0;
          // Accept while stopping: shadow would apply at once, so load directly.
          if (accept) begin
            div0_cur_d = cfg.cfg_div0;
            div1_cur_d = cfg.cfg_div1;
            done_d     = 1'b1;
          end
        end else begin
          c0_d  = term0 ? '0 : c0_q + CNT_W'(1);
          c1_d  = term1 ? '0 : c1_q + CNT_W'(1);
          en0_d = term0;
          en1_d = term1;
          if (accept) begin
            sh0_d   = cfg.cfg_div0;
            sh1_d   = cfg.cfg_div1;
            state_d = PEND;
          end
        end
      end

      PEND: begin
        if (!run) begin
          state_d    = IDLE;
          c0_d       = '0;
          c1_d       = '0;
          div0_cur_d = sh0_q;
          div1_cur_d = sh1_q;
          done_d     = 1'b1;
          apply      = 1'b1;
        end else begin
          c0_d  = term0 ? '0 : c0_q + CNT_W'(1);
          c1_d  = term1 ? '0 : c1_q + CNT_W'(1);
          en0_d = term0;
          en1_d = term1;
          // Apply on the en0 boundary: both counters restart in phase.
          if (term0) begin
            c0_d       = '0;
            c1_d       = '0;
            div0_cur_d = sh0_q;
            div1_cur_d = sh1_q;
            done_d     = 1'b1;
            apply      = 1'b1;
            state_d    = RUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d != PEND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      c0_q       <= '0;
      c1_q       <= '0;
      div0_cur_q <= CNT_W'(DIV0_RST);
      div1_cur_q <= CNT_W'(DIV1_RST);
      sh0_q      <= '0;
      sh1_q      <= '0;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      div0_cur_q <= div0_cur_d;
      div1_cur_q <= div1_cur_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign en0           = en0_q;
  assign en1           = en1_q;
  assign busy          = busy_q;
  assign div0_cur      = div0_cur_q;
  assign div1_cur      = div1_cur_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_done  = done_q;

`ifdef SQUARE_OUT_EN
  logic sq0_q, sq0_d, sq1_q, sq1_d;

  always_comb begin
    sq0_d = sq0_q ^ en0_q;
    sq1_d = sq1_q ^ en1_q;
    if (state_q == IDLE || apply) begin
      sq0_d = 1'b0;
      sq1_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sq0_q <= 1'b0;
      sq1_q <= 1'b0;
    end else begin
      sq0_q <= sq0_d;
      sq1_q <= sq1_d;
    end
  end

  assign sq0 = sq0_q;
  assign sq1 = sq1_q;
`endif

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed bench for clk_en_ctrl. Inputs change and outputs are sampled on
// the falling edge; sample k is the one after the k-th rising edge following
// the edge that first samples run=1.
module tb_clk_en_ctrl;

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b0;
  logic       run     = 1'b0;
  logic       en0, en1, busy;
  logic [7:0] div0_cur, div1_cur;
`ifdef SQUARE_OUT_EN
  logic       sq0, sq1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  clk_en_ctrl_if #(.CNT_W(8)) cfg_if ();

  clk_en_ctrl #(
    .CNT_W   (8),
    .DIV0_RST(4),
    .DIV1_RST(2)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .run     (run),
    .cfg     (cfg_if),
    .en0     (en0),
    .en1     (en1),
    .busy    (busy),
    .div0_cur(div0_cur),
    .div1_cur(div1_cur)
`ifdef SQUARE_OUT_EN
    ,
    .sq0     (sq0),
    .sq1     (sq1)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div0  = '0;
    cfg_if.cfg_div1  = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and default 4/2 ratios.
    do_reset();
    check("rst_en0", en0, 0);
    check("rst_en1", en1, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    check("rst_done", cfg_if.cfg_done, 0);
    check("rst_div0", div0_cur, 4);
    check("rst_div1", div1_cur, 2);
    run = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      check("def_en0", en0, (k > 0 && k % 4 == 0) ? 1 : 0);
      check("def_en1", en1, (k > 0 && k % 2 == 0) ? 1 : 0);
    end
    check("def_busy", busy, 1);

    // Config accepted in IDLE, then run at 6/3.
    do_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div0  = 8'd6;
    cfg_if.cfg_div1  = 8'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("idle_done", cfg_if.cfg_done, 1);
    check("idle_div0", div0_cur, 6);
    check("idle_div1", div1_cur, 3);
    step();
    check("idle_done_end", cfg_if.cfg_done, 0);
    run = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      check("r63_en0", en0, (k > 0 && k % 6 == 0) ? 1 : 0);
      check("r63_en1", en1, (k > 0 && k % 3 == 0) ? 1 : 0);
    end

    // Config accepted in RUN: applied on the en0 boundary at sample 8.
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 5; k++) step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div0  = 8'd8;
    cfg_if.cfg_div1  = 8'd1;
    step();                               // sample 6
    cfg_if.cfg_valid = 1'b0;
    check("pend_ready6", cfg_if.cfg_ready, 0);
    check("pend_done6", cfg_if.cfg_done, 0);
    check("pend_div0_6", div0_cur, 4);
    step();                               // sample 7
    check("pend_ready7", cfg_if.cfg_ready, 0);
    check("pend_en0_7", en0, 0);
    step();                               // sample 8: apply
    check("apply_en0", en0, 1);
    check("apply_en1", en1, 1);
    check("apply_done", cfg_if.cfg_done, 1);
    check("apply_ready", cfg_if.cfg_ready, 1);
    check("apply_div0", div0_cur, 8);
    check("apply_div1", div1_cur, 1);
    for (int k = 9; k <= 16; k++) begin
      step();
      check("new_en1", en1, 1);
      check("new_en0", en0, (k == 16) ? 1 : 0);
      check("new_done", cfg_if.cfg_done, 0);
    end

    // Zero ratio on en0.
    do_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div0  = 8'd0;
    cfg_if.cfg_div1  = 8'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("zero_div0", div0_cur, 0);
    run = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step();
      check("zero_en0", en0, (k > 0) ? 1 : 0);
      check("zero_en1", en1, (k > 0 && k % 2 == 0) ? 1 : 0);
    end

    // run drop in RUN: the already registered en0 completes.
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 4; k++) step();
    run = 1'b0;
    check("drop_en0_hold", en0, 1);
    step();
    check("drop_en0", en0, 0);
    check("drop_busy", busy, 0);
    step();
    check("drop_en1", en1, 0);

    // run drop in PEND: immediate apply, back to IDLE.
    do_reset();
    run = 1'b1;
    step();
    step();                               // sample 1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div0  = 8'd6;
    cfg_if.cfg_div1  = 8'd3;
    step();                               // sample 2, PEND
    cfg_if.cfg_valid = 1'b0;
    run              = 1'b0;
    check("pdrop_ready", cfg_if.cfg_ready, 0);
    check("pdrop_en1_hold", en1, 1);
    step();                               // sample 3
    check("pdrop_done", cfg_if.cfg_done, 1);
    check("pdrop_busy", busy, 0);
    check("pdrop_ready_back", cfg_if.cfg_ready, 1);
    check("pdrop_div0", div0_cur, 6);
    check("pdrop_div1", div1_cur, 3);
    check("pdrop_en0", en0, 0);
    check("pdrop_en1", en1, 0);
    step();
    check("pdrop_done_end", cfg_if.cfg_done, 0);

    // Async reset in PEND: no edge needed, shadow discarded.
    do_reset();
    run = 1'b1;
    step();
    step();                               // sample 1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div0  = 8'd8;
    cfg_if.cfg_div1  = 8'd1;
    step();                               // sample 2, PEND, en1 high
    cfg_if.cfg_valid = 1'b0;
    check("ar_pend_ready", cfg_if.cfg_ready, 0);
    check("ar_en1_before", en1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_en0", en0, 0);
    check("ar_en1", en1, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", cfg_if.cfg_ready, 1);
    check("ar_done", cfg_if.cfg_done, 0);
    check("ar_div0", div0_cur, 4);
    check("ar_div1", div1_cur, 2);
    step();
    reset_n = 1'b1;                       // run still 1
    for (int k = 0; k <= 9; k++) begin
      step();
      check("ar_post_en0", en0, (k > 0 && k % 4 == 0) ? 1 : 0);
      check("ar_post_done", cfg_if.cfg_done, 0);
    end
    check("ar_post_div0", div0_cur, 4);
    check("ar_post_div1", div1_cur, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
